// File: rtl/tick_period_monitor_pkg.sv
// Shared definitions for the tick delay/monitor family: FSM encodings,
// the 50 MHz millisecond prescaler default and a saturating increment helper.
package tick_period_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOST = 2'd2
    } state_t;

    localparam logic [15:0] T1MSVAL_DEFAULT = 16'd49999;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ms_strobe_gen.sv
// Millisecond prescaler: pulses ms_stb once every T1MSVAL+1 clocks and
// restarts its count on a synchronous clear.
module ms_strobe_gen
    import tick_period_monitor_pkg::*;
#(
    parameter logic [15:0] T1MSVAL = T1MSVAL_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    output logic ms_stb
);

    logic [15:0] pre_cnt;
    logic [15:0] pre_now;

    // The clearing cycle itself is prescaler step 0, so the downstream ms
    // count equals floor(clocks since the clear / (T1MSVAL+1)).
    always_comb begin
        pre_now = clear ? 16'd0 : pre_cnt;
    end

    assign ms_stb = (pre_now == T1MSVAL);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_cnt <= 16'd0;
        end else if (ms_stb) begin
            pre_cnt <= 16'd0;
        end else begin
            pre_cnt <= pre_now + 16'd1;
        end
    end

endmodule

// File: rtl/tick_period_monitor.sv
// Health monitor for a periodic one-cycle tick: measures the interval between
// rising edges in whole ms, flags out-of-window periods, tick loss and lock.
module tick_period_monitor
    import tick_period_monitor_pkg::*;
#(
    parameter logic [15:0] T1MSVAL    = T1MSVAL_DEFAULT,
    parameter logic [15:0] N_MS       = 16'd100,
    parameter logic [15:0] TOL_MS     = 16'd2,
    parameter logic [15:0] TIMEOUT_MS = 16'd255,
    parameter logic [3:0]  LOCK_CNT   = 4'd4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        tick_in,
    output logic [15:0] period_ms,
    output logic        period_valid,
    output logic        early_err,
    output logic        late_err,
    output logic        timeout,
    output logic        locked
);

    localparam logic [16:0] LOW_BOUND  = {1'b0, N_MS} - {1'b0, TOL_MS};
    localparam logic [16:0] HIGH_BOUND = {1'b0, N_MS} + {1'b0, TOL_MS};

    state_t      state;
    state_t      next_state;
    logic        tick_d;
    logic        tick_edge;
    logic        ms_stb;
    logic [15:0] ms_cnt;
    logic [3:0]  good_cnt;
    logic        measure;
    logic        enter_lost;
    logic        is_early;
    logic        is_late;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_d <= 1'b0;
        end else begin
            tick_d <= tick_in;
        end
    end

    assign tick_edge = tick_in & ~tick_d;

    ms_strobe_gen #(
        .T1MSVAL (T1MSVAL)
    ) u_strobe (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (tick_edge),
        .ms_stb (ms_stb)
    );

    // An edge wins over a coincident strobe, so that ms is never counted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ms_cnt <= 16'd0;
        end else if (tick_edge) begin
            ms_cnt <= 16'd0;
        end else if (ms_stb) begin
            ms_cnt <= sat_inc16(ms_cnt);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (tick_edge) next_state = ST_RUN;
            ST_RUN:  if (!tick_edge && (ms_cnt == TIMEOUT_MS)) next_state = ST_LOST;
            ST_LOST: if (tick_edge) next_state = ST_RUN;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        measure    = (state == ST_RUN) && tick_edge;
        enter_lost = (state == ST_RUN) && (next_state == ST_LOST);
        timeout    = (state == ST_LOST);
    end

    always_comb begin
        is_early = ({1'b0, ms_cnt} < LOW_BOUND);
        is_late  = ({1'b0, ms_cnt} > HIGH_BOUND);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            period_ms    <= 16'd0;
            period_valid <= 1'b0;
            early_err    <= 1'b0;
            late_err     <= 1'b0;
        end else begin
            period_valid <= measure;
            early_err    <= measure && is_early;
            late_err     <= measure && is_late;
            if (measure) begin
                period_ms <= ms_cnt;
            end
        end
    end

    // Lock follows the good-period run one clock later than the count itself.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            good_cnt <= 4'd0;
            locked   <= 1'b0;
        end else begin
            locked <= (good_cnt >= LOCK_CNT);
            if (enter_lost || (measure && (is_early || is_late))) begin
                good_cnt <= 4'd0;
            end else if (measure && (good_cnt != 4'hF)) begin
                good_cnt <= good_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Self-checking bench for tick_period_monitor: table-driven intervals, corner
// sequences (timeout, held-high tick, mid-interval reset) and random intervals.
module tb_tick_period_monitor;

    localparam int CLKS_PER_MS = 10;
    localparam int NOM         = 5;
    localparam int TOL         = 1;
    localparam int TMO         = 12;
    localparam int LOCKN       = 3;
    localparam int MODE_IDLE   = 0;
    localparam int MODE_RUN    = 1;
    localparam int MODE_LOST   = 2;

    typedef struct {
        int interval;
        int width;
        int exp_period;
        int exp_early;
        int exp_late;
        int exp_locked;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        tick_in;
    logic [15:0] period_ms;
    logic        period_valid;
    logic        early_err;
    logic        late_err;
    logic        timeout;
    logic        locked;

    int n_compared   = 0;
    int n_mismatched = 0;
    int valid_pulses = 0;

    int m_mode, m_elapsed, m_good, m_prev, m_period;
    int m_valid, m_early, m_late, m_timeout, m_locked;

    vec_t tbl[17];

    tick_period_monitor #(
        .T1MSVAL    (16'd9),
        .N_MS       (16'd5),
        .TOL_MS     (16'd1),
        .TIMEOUT_MS (16'd12),
        .LOCK_CNT   (4'd3)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .tick_in      (tick_in),
        .period_ms    (period_ms),
        .period_valid (period_valid),
        .early_err    (early_err),
        .late_err     (late_err),
        .timeout      (timeout),
        .locked       (locked)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input int iv, input int w, input int p,
                                input int e, input int l, input int lk);
        vec_t v;
        v.interval = iv; v.width = w; v.exp_period = p;
        v.exp_early = e; v.exp_late = l; v.exp_locked = lk;
        return v;
    endfunction

    function automatic void model_reset();
        m_mode = MODE_IDLE; m_elapsed = 0; m_good = 0; m_prev = 0; m_period = 0;
        m_valid = 0; m_early = 0; m_late = 0; m_timeout = 0; m_locked = 0;
    endfunction

    // Reference: the period is elapsed clocks since the last edge divided by
    // the clocks per ms, evaluated in the cycle of the next edge.
    function automatic void model_step(input int t);
        int e;
        int ms;
        e = (t != 0 && m_prev == 0) ? 1 : 0;
        m_prev = t;
        ms = m_elapsed / CLKS_PER_MS;
        if (ms > 65535) ms = 65535;
        m_locked = (m_good >= LOCKN) ? 1 : 0;
        m_valid = 0; m_early = 0; m_late = 0;
        if (e != 0) begin
            if (m_mode == MODE_RUN) begin
                m_valid  = 1;
                m_period = ms;
                m_early  = (ms < NOM - TOL) ? 1 : 0;
                m_late   = (ms > NOM + TOL) ? 1 : 0;
                if (m_early != 0 || m_late != 0) m_good = 0;
                else if (m_good < 15) m_good++;
            end
            m_mode = MODE_RUN;
            m_elapsed = 1;
        end else begin
            if (m_mode == MODE_RUN && ms == TMO) begin
                m_mode = MODE_LOST;
                m_good = 0;
            end
            m_elapsed++;
        end
        m_timeout = (m_mode == MODE_LOST) ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        check("model_period_ms",    32'(period_ms),    32'(m_period));
        check("model_period_valid", 32'(period_valid), 32'(m_valid));
        check("model_early_err",    32'(early_err),    32'(m_early));
        check("model_late_err",     32'(late_err),     32'(m_late));
        check("model_timeout",      32'(timeout),      32'(m_timeout));
        check("model_locked",       32'(locked),       32'(m_locked));
    endtask

    task automatic applyStimulus(input logic t);
        tick_in = t;
        model_step(int'(t));
        @(negedge CLK);
        if (period_valid === 1'b1) valid_pulses++;
        checkOutput();
    endtask

    // One tick of the given width followed by low cycles up to the interval;
    // exp describes the interval that this tick's edge closes.
    task automatic emit_tick(input int width, input int interval, input bit has_exp, input vec_t exp);
        for (int c = 0; c < interval; c++) begin
            applyStimulus(c < width);
            if (c == 0) begin
                if (has_exp) begin
                    check("meas_valid",  32'(period_valid), 32'd1);
                    check("meas_period", 32'(period_ms),    32'(exp.exp_period));
                    check("meas_early",  32'(early_err),    32'(exp.exp_early));
                    check("meas_late",   32'(late_err),     32'(exp.exp_late));
                end else begin
                    check("no_meas_valid", 32'(period_valid), 32'd0);
                end
            end else if (c == 1 && has_exp) begin
                check("meas_locked", 32'(locked), 32'(exp.exp_locked));
            end
        end
    endtask

    initial begin
        tbl[0]  = mk(50, 1, 5, 0, 0, 0);
        tbl[1]  = mk(50, 2, 5, 0, 0, 0);
        tbl[2]  = mk(50, 1, 5, 0, 0, 1);
        tbl[3]  = mk(50, 1, 5, 0, 0, 1);
        tbl[4]  = mk(30, 1, 3, 1, 0, 0);
        tbl[5]  = mk(50, 4, 5, 0, 0, 0);
        tbl[6]  = mk(50, 1, 5, 0, 0, 0);
        tbl[7]  = mk(50, 1, 5, 0, 0, 1);
        tbl[8]  = mk(72, 1, 7, 0, 1, 0);
        tbl[9]  = mk(49, 3, 4, 0, 0, 0);
        tbl[10] = mk(40, 1, 4, 0, 0, 0);
        tbl[11] = mk(69, 1, 6, 0, 0, 1);
        tbl[12] = mk(70, 1, 7, 0, 1, 0);
        tbl[13] = mk(39, 1, 3, 1, 0, 0);
        tbl[14] = mk(120, 1, 12, 0, 1, 0);
        tbl[15] = mk(20, 1, 2, 1, 0, 0);
        tbl[16] = mk(50, 1, 5, 0, 0, 0);

        RST = 1'b1;
        tick_in = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        checkOutput();
        RST = 1'b0;

        $display("[TB] table-driven intervals");
        for (int i = 0; i < 17; i++) begin
            emit_tick(tbl[i].width, tbl[i].interval, i > 0, (i > 0) ? tbl[i-1] : tbl[0]);
        end

        $display("[TB] tick loss");
        emit_tick(1, 2, 1'b1, tbl[16]);
        for (int c = 2; c <= 125; c++) begin
            applyStimulus(1'b0);
            if (c == 119) check("timeout_before", 32'(timeout), 32'd0);
            if (c == 120) check("timeout_rise",   32'(timeout), 32'd1);
            if (c == 121) check("locked_lost",    32'(locked),  32'd0);
        end
        applyStimulus(1'b1);
        check("lost_edge_no_valid", 32'(period_valid), 32'd0);
        check("lost_edge_timeout",  32'(timeout),      32'd0);
        for (int c = 1; c < 50; c++) applyStimulus(1'b0);
        emit_tick(1, 50, 1'b1, mk(50, 1, 5, 0, 0, 0));

        $display("[TB] held-high tick");
        valid_pulses = 0;
        emit_tick(20, 50, 1'b1, mk(50, 1, 5, 0, 0, 0));
        check("held_single_event", 32'(valid_pulses), 32'd1);
        emit_tick(1, 20, 1'b1, mk(50, 20, 5, 0, 0, 1));
        check("locked_before_reset", 32'(locked), 32'd1);

        $display("[TB] mid-interval reset");
        #2 RST = 1'b1;
        model_reset();
        #1;
        checkOutput();
        check("reset_locked",  32'(locked),       32'd0);
        check("reset_valid",   32'(period_valid), 32'd0);
        check("reset_period",  32'(period_ms),    32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        emit_tick(1, 50, 1'b0, mk(0, 0, 0, 0, 0, 0));
        emit_tick(1, 50, 1'b1, mk(50, 1, 5, 0, 0, 0));

        $display("[TB] random intervals");
        for (int i = 0; i < 40; i++) begin
            int iv;
            int w;
            iv = int'($urandom_range(135, 2));
            w  = int'($urandom_range(iv - 1, 1));
            for (int c = 0; c < iv; c++) applyStimulus(c < w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
